// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Initiator for the BreadBoard ALU command interface. A request is accepted
// over a valid/ready handshake, and its operands and command are driven onto
// the ALU's combinational inputs. The inputs are held for SETTLE_CYCLES
// clocks, then the result and overflow flag are captured. Finally they are
// returned over a valid/ready response handshake.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. Once valid is raised, the payload stays stable
// until that transfer.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_op                  00=ADD, 01=SUB, 1x=illegal
//   req_a, req_b            16-bit operands
//   alu_a, alu_b            operands driven to the ALU
//   alu_command             4-bit ALU command (CMD_IDLE when inactive)
//   alu_result, alu_error   ALU sign-extended result and overflow flag
//   rsp_valid/rsp_ready     response handshake
//   rsp_result, rsp_error   captured ALU result and overflow flag
//   rsp_illegal, rsp_op     illegal-op marker and echoed op
//   txn_count               completed-response counter (wraps)
//   dbg_state               current FSM state, for observation
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
   parameter int         SETTLE_CYCLES = 4,
   parameter logic [3:0] CMD_ADD       = 4'b0001,
   parameter logic [3:0] CMD_SUB       = 4'b0101,
   parameter logic [3:0] CMD_IDLE      = 4'b0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [3:0]  alu_command,
   input  logic [31:0] alu_result,
   input  logic        alu_error,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_error,
   output logic        rsp_illegal,
   output logic [1:0]  rsp_op,
   output logic [7:0]  txn_count,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      RESPOND = 2'd3
   } state_t;

   // The counter is loaded with SETTLE_CYCLES-1 on acceptance. The FSM then
   // leaves SETTLE on the cycle the counter reads zero. This gives exactly
   // SETTLE_CYCLES clocks from the handshake to CAPTURE entry.
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t      state_q, state_d;
   logic [15:0] alu_a_q, alu_a_d;
   logic [15:0] alu_b_q, alu_b_d;
   logic [3:0]  alu_cmd_q, alu_cmd_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] rsp_result_q, rsp_result_d;
   logic        rsp_error_q, rsp_error_d;
   logic        rsp_illegal_q, rsp_illegal_d;
   logic [1:0]  rsp_op_q, rsp_op_d;
   logic [7:0]  txn_count_q, txn_count_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_cmd_q     <= CMD_IDLE;
         cnt_q         <= '0;
         op_q          <= '0;
         rsp_result_q  <= '0;
         rsp_error_q   <= 1'b0;
         rsp_illegal_q <= 1'b0;
         rsp_op_q      <= '0;
         txn_count_q   <= '0;
      end else begin
         state_q       <= state_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_cmd_q     <= alu_cmd_d;
         cnt_q         <= cnt_d;
         op_q          <= op_d;
         rsp_result_q  <= rsp_result_d;
         rsp_error_q   <= rsp_error_d;
         rsp_illegal_q <= rsp_illegal_d;
         rsp_op_q      <= rsp_op_d;
         txn_count_q   <= txn_count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      alu_cmd_d     = alu_cmd_q;
      cnt_d         = cnt_q;
      op_d          = op_q;
      rsp_result_d  = rsp_result_q;
      rsp_error_d   = rsp_error_q;
      rsp_illegal_d = rsp_illegal_q;
      rsp_op_d      = rsp_op_q;
      txn_count_d   = txn_count_q;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (!req_op[1]) begin
                  alu_a_d   = req_a;
                  alu_b_d   = req_b;
                  alu_cmd_d = req_op[0] ? CMD_SUB : CMD_ADD;
                  op_d      = req_op;
                  cnt_d     = SETTLE_LOAD;
                  state_d   = SETTLE;
               end else begin
                  // Illegal op: the ALU is never touched, and the response
                  // is built directly.
                  rsp_result_d  = '0;
                  rsp_error_d   = 1'b0;
                  rsp_illegal_d = 1'b1;
                  rsp_op_d      = req_op;
                  state_d       = RESPOND;
               end
            end
         end
         SETTLE: begin
            if (cnt_q == 4'd0) begin
               state_d = CAPTURE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         CAPTURE: begin
            rsp_result_d  = alu_result;
            rsp_error_d   = alu_error;
            rsp_illegal_d = 1'b0;
            rsp_op_d      = op_q;
            alu_cmd_d     = CMD_IDLE;
            state_d       = RESPOND;
         end
         RESPOND: begin
            if (rsp_ready) begin
               txn_count_d = txn_count_q + 8'd1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_ready   = (state_q == IDLE);
   assign rsp_valid   = (state_q == RESPOND);
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_command = alu_cmd_q;
   assign rsp_result  = rsp_result_q;
   assign rsp_error   = rsp_error_q;
   assign rsp_illegal = rsp_illegal_q;
   assign rsp_op      = rsp_op_q;
   assign txn_count   = txn_count_q;
   assign dbg_state   = state_q;

endmodule
